// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
//
// Age-ordered, collapsing out-of-order issue queue with a physical-register
// busy table and writeback wakeup.
//
// Rename enqueues instructions. Each source captures a ready bit at enqueue
// time. Writeback broadcasts set the ready bits of waiting sources. The oldest
// entry whose sources are both ready is presented to execute.
//
// Handshakes (both directions use strict valid/ready semantics):
//   A transfer happens on a rising edge where valid && ready are both high.
//   The producer holds valid and payload stable until that transfer.
//   The consumer's ready never depends combinationally on valid.
//   - in_ready depends only on count (count < DEPTH).
//   - iss_valid and the iss_* payload come only from registered state.
//     A wakeup therefore takes effect one cycle later.
//
// Ports
//   clk, rstn          rising-edge clock, synchronous active-low reset
//   flush              invalidates every entry at the next edge; any
//                      enqueue or issue in that cycle is dropped; the busy
//                      table keeps its contents
//   in_valid/in_ready  enqueue handshake from rename
//   in_*               enqueue payload
//   wb_valid, wb_preg  writeback wakeup broadcast
//   iss_valid/iss_ready issue handshake to execute
//   iss_*              issue payload (oldest ready entry)
//   count              number of valid entries
// -----------------------------------------------------------------------------
module issue_queue #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             in_opcode,
  input  logic [PREG_W-1:0]      in_sr1_p,
  input  logic [PREG_W-1:0]      in_sr2_p,
  input  logic                   in_has_imm,
  input  logic [31:0]            in_imm,
  input  logic [PREG_W-1:0]      in_dr_p,
  input  logic                   in_wr_en,
  input  logic [ROB_W-1:0]       in_rob,
  input  logic                   wb_valid,
  input  logic [PREG_W-1:0]      wb_preg,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [6:0]             iss_opcode,
  output logic [PREG_W-1:0]      iss_sr1_p,
  output logic [PREG_W-1:0]      iss_sr2_p,
  output logic                   iss_has_imm,
  output logic [31:0]            iss_imm,
  output logic [PREG_W-1:0]      iss_dr_p,
  output logic                   iss_wr_en,
  output logic [ROB_W-1:0]       iss_rob,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = IW + 1;
  localparam int NPREG = 1 << PREG_W;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [PREG_W-1:0] sr1_p;
    logic [PREG_W-1:0] sr2_p;
    logic              has_imm;
    logic [31:0]       imm;
    logic [PREG_W-1:0] dr_p;
    logic              wr_en;
    logic [ROB_W-1:0]  rob;
    logic              rdy1;
    logic              rdy2;
  } entry_t;

  // Slot i holds a valid entry exactly when i < count_q.
  // Slot 0 is the oldest.
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [NPREG-1:0] busy_q, busy_d;

  // woken has one extra all-zero slot.
  // The collapse can then read slot j+1 for every j without a range special case.
  entry_t           woken [DEPTH+1];
  entry_t           new_ent;
  logic [CW-1:0]    enq_slot;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic             do_enq;
  logic             do_iss;

  assign in_ready = (count_q < CW'(DEPTH));
  assign count    = count_q;

  // Oldest-first select over the stored ready bits only.
  // The descending scan leaves the lowest matching index in sel_idx.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CW'(i) < count_q && ent_q[i].rdy1 && ent_q[i].rdy2) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign iss_valid   = sel_found;
  assign iss_opcode  = ent_q[sel_idx].opcode;
  assign iss_sr1_p   = ent_q[sel_idx].sr1_p;
  assign iss_sr2_p   = ent_q[sel_idx].sr2_p;
  assign iss_has_imm = ent_q[sel_idx].has_imm;
  assign iss_imm     = ent_q[sel_idx].imm;
  assign iss_dr_p    = ent_q[sel_idx].dr_p;
  assign iss_wr_en   = ent_q[sel_idx].wr_en;
  assign iss_rob     = ent_q[sel_idx].rob;

  assign do_enq = in_valid && in_ready && !flush;
  assign do_iss = sel_found && iss_ready && !flush;

  // Incoming entry.
  // A writeback in the same cycle counts as ready, so a source whose
  // producer is finishing right now is not missed.
  // Preg 0 is hard-wired ready.
  always_comb begin
    new_ent         = '0;
    new_ent.opcode  = in_opcode;
    new_ent.sr1_p   = in_sr1_p;
    new_ent.sr2_p   = in_sr2_p;
    new_ent.has_imm = in_has_imm;
    new_ent.imm     = in_imm;
    new_ent.dr_p    = in_dr_p;
    new_ent.wr_en   = in_wr_en;
    new_ent.rob     = in_rob;
    new_ent.rdy1    = (in_sr1_p == '0) || !busy_q[in_sr1_p] ||
                      (wb_valid && wb_preg == in_sr1_p);
    new_ent.rdy2    = in_has_imm || (in_sr2_p == '0) || !busy_q[in_sr2_p] ||
                      (wb_valid && wb_preg == in_sr2_p);
  end

  always_comb begin
    // Wakeup is applied to every slot before the collapse.
    // An entry that shifts down keeps the wakeup it received this cycle.
    for (int j = 0; j < DEPTH; j++) begin
      woken[j] = ent_q[j];
      if (wb_valid && ent_q[j].sr1_p == wb_preg) woken[j].rdy1 = 1'b1;
      if (wb_valid && ent_q[j].sr2_p == wb_preg) woken[j].rdy2 = 1'b1;
    end
    woken[DEPTH] = '0;

    // The new entry lands at count after any same-cycle removal.
    enq_slot = do_iss ? (count_q - CW'(1)) : count_q;

    for (int j = 0; j < DEPTH; j++) begin
      if (do_iss && IW'(j) >= sel_idx) ent_d[j] = woken[j+1];
      else                             ent_d[j] = woken[j];
      if (do_enq && CW'(j) == enq_slot) ent_d[j] = new_ent;
    end

    // Flush only zeroes count.
    // Stale slot contents are unreachable once count is 0.
    count_d = count_q;
    if (flush)                  count_d = '0;
    else if (do_enq && !do_iss) count_d = count_q + CW'(1);
    else if (!do_enq && do_iss) count_d = count_q - CW'(1);

    // The set is applied after the clear.
    // If a new producer and a writeback name the same preg, the preg stays busy.
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_preg] = 1'b0;
    if (do_enq && in_wr_en && in_dr_p != '0) busy_d[in_dr_p] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
      busy_q  <= '0;
      for (int j = 0; j < DEPTH; j++) ent_q[j] <= '0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      for (int j = 0; j < DEPTH; j++) ent_q[j] <= ent_d[j];
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_issue_queue
//
// Directed bench for issue_queue (DEPTH=8, PREG_W=6, ROB_W=16).
// The driver pushes the expected issue payload into exp_q when it offers an
// instruction that should eventually issue. The monitor pops and compares on
// every accepted issue. Inputs change 1 time unit after the rising edge.
// The monitor samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_issue_queue;

  localparam int PW = 75;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [5:0]  in_sr1_p;
  logic [5:0]  in_sr2_p;
  logic        in_has_imm;
  logic [31:0] in_imm;
  logic [5:0]  in_dr_p;
  logic        in_wr_en;
  logic [15:0] in_rob;
  logic        wb_valid;
  logic [5:0]  wb_preg;
  logic        iss_valid;
  logic        iss_ready;
  logic [6:0]  iss_opcode;
  logic [5:0]  iss_sr1_p;
  logic [5:0]  iss_sr2_p;
  logic        iss_has_imm;
  logic [31:0] iss_imm;
  logic [5:0]  iss_dr_p;
  logic        iss_wr_en;
  logic [15:0] iss_rob;
  logic [3:0]  count;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] mon_got;
  logic [PW-1:0] mon_exp;
  int            n_checks = 0;
  int            n_errors = 0;

  issue_queue #(.DEPTH(8), .PREG_W(6), .ROB_W(16)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_sr1_p(in_sr1_p), .in_sr2_p(in_sr2_p),
    .in_has_imm(in_has_imm), .in_imm(in_imm), .in_dr_p(in_dr_p),
    .in_wr_en(in_wr_en), .in_rob(in_rob),
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_sr1_p(iss_sr1_p), .iss_sr2_p(iss_sr2_p),
    .iss_has_imm(iss_has_imm), .iss_imm(iss_imm), .iss_dr_p(iss_dr_p),
    .iss_wr_en(iss_wr_en), .iss_rob(iss_rob),
    .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [PW-1:0] pack(input logic [6:0] op, input logic [5:0] s1,
                                         input logic [5:0] s2, input logic hi,
                                         input logic [31:0] imm, input logic [5:0] dr,
                                         input logic wr, input logic [15:0] rob);
    return {op, s1, s2, hi, imm, dr, wr, rob};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    in_opcode  = '0;
    in_sr1_p   = '0;
    in_sr2_p   = '0;
    in_has_imm = 1'b0;
    in_imm     = '0;
    in_dr_p    = '0;
    in_wr_en   = 1'b0;
    in_rob     = '0;
    wb_valid   = 1'b0;
    wb_preg    = '0;
  endtask

  // Offers one instruction this cycle.
  // When will_issue is set, its payload becomes the next expected issue.
  task automatic set_enq(input logic [6:0] op, input logic [5:0] s1, input logic [5:0] s2,
                         input logic hi, input logic [31:0] imm, input logic [5:0] dr,
                         input logic wr, input logic [15:0] rob, input bit will_issue);
    in_valid   = 1'b1;
    in_opcode  = op;
    in_sr1_p   = s1;
    in_sr2_p   = s2;
    in_has_imm = hi;
    in_imm     = imm;
    in_dr_p    = dr;
    in_wr_en   = wr;
    in_rob     = rob;
    if (will_issue) exp_q.push_back(pack(op, s1, s2, hi, imm, dr, wr, rob));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rstn && !flush && iss_valid && iss_ready) begin
      mon_got = pack(iss_opcode, iss_sr1_p, iss_sr2_p, iss_has_imm, iss_imm,
                     iss_dr_p, iss_wr_en, iss_rob);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL issue_unexpected actual=%h expected=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_errors++;
          $display("FAIL issue_payload actual=%h expected=%h", mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rstn = 1'b0;
    flush = 1'b0;
    iss_ready = 1'b0;
    idle_in();
    repeat (3) step();
    rstn = 1'b1;
    chk("reset_count", count, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_iss_valid", iss_valid, 0);

    // Back-to-back dependency: A writes p33, B reads p33.
    iss_ready = 1'b1;
    set_enq(7'h01, 6'd1, 6'd2, 1'b0, 32'h0, 6'd33, 1'b1, 16'd1, 1);
    step();
    set_enq(7'h02, 6'd33, 6'd0, 1'b1, 32'h11, 6'd34, 1'b1, 16'd2, 1);
    chk("dep_a_valid", iss_valid, 1);
    chk("dep_a_rob", iss_rob, 1);
    step();
    idle_in();
    chk("dep_b_wait0", iss_valid, 0);
    chk("dep_b_count", count, 1);
    step();
    wb_valid = 1'b1;
    wb_preg  = 6'd33;
    chk("dep_b_no_bypass", iss_valid, 0);
    step();
    idle_in();
    chk("dep_b_woken", iss_valid, 1);
    chk("dep_b_rob", iss_rob, 2);
    step();
    chk("dep_empty", count, 0);

    // Fill with sources waiting on p34, still busy from B.
    for (int i = 0; i < 8; i++) begin
      set_enq(7'h10 + 7'(i), 6'd34, 6'd0, 1'b1, 32'(i), 6'd0, 1'b0, 16'(10 + i), 1);
      step();
    end
    idle_in();
    chk("full_count", count, 8);
    chk("full_in_ready", in_ready, 0);
    chk("full_iss_valid", iss_valid, 0);
    set_enq(7'h7f, 6'd1, 6'd0, 1'b1, 32'h99, 6'd0, 1'b0, 16'd99, 0);
    step();
    idle_in();
    chk("ninth_refused", count, 8);

    // Wake all eight entries.
    // The issue cycle at count 8 still refuses enqueue, because in_ready
    // looks at count only. The collapse-plus-append path is then exercised
    // at count 7, with the new entry landing behind all older ones.
    iss_ready = 1'b0;
    wb_valid  = 1'b1;
    wb_preg   = 6'd34;
    step();
    idle_in();
    iss_ready = 1'b1;
    chk("full_issue_valid", iss_valid, 1);
    chk("full_issue_rob", iss_rob, 10);
    chk("full_issue_in_ready", in_ready, 0);
    set_enq(7'h7e, 6'd1, 6'd0, 1'b1, 32'h98, 6'd0, 1'b0, 16'd98, 0);
    step();
    chk("after_issue_count", count, 7);
    chk("after_issue_in_ready", in_ready, 1);
    set_enq(7'h20, 6'd1, 6'd0, 1'b1, 32'h20, 6'd0, 1'b0, 16'd20, 1);
    chk("enq_iss_rob", iss_rob, 11);
    step();
    idle_in();
    chk("enq_iss_count_held", count, 7);
    repeat (7) step();
    chk("drain_count", count, 0);

    // Same-cycle enqueue and writeback of the source preg.
    set_enq(7'h30, 6'd1, 6'd2, 1'b0, 32'h30, 6'd40, 1'b1, 16'd30, 1);
    step();
    set_enq(7'h31, 6'd40, 6'd0, 1'b1, 32'h31, 6'd0, 1'b0, 16'd31, 1);
    wb_valid = 1'b1;
    wb_preg  = 6'd40;
    chk("wb_bypass_p_rob", iss_rob, 30);
    step();
    idle_in();
    chk("wb_bypass_valid", iss_valid, 1);
    chk("wb_bypass_rob", iss_rob, 31);
    step();
    chk("wb_bypass_empty", count, 0);

    // Stall: payload must hold for 3 cycles, then issue.
    iss_ready = 1'b0;
    set_enq(7'h45, 6'd3, 6'd4, 1'b0, 32'hdeadbeef, 6'd5, 1'b1, 16'd40, 1);
    step();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", iss_valid, 1);
      chk("stall_rob", iss_rob, 40);
      chk("stall_imm", iss_imm, 32'hdeadbeef);
      chk("stall_opcode", iss_opcode, 7'h45);
      step();
    end
    iss_ready = 1'b1;
    chk("stall_release_valid", iss_valid, 1);
    step();
    chk("stall_empty", count, 0);

    // Flush with 5 entries, then reset mid-stream.
    iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_enq(7'h50, 6'd1, 6'd0, 1'b1, 32'h0, (i == 0) ? 6'd33 : 6'd0,
              (i == 0), 16'(60 + i), 0);
      step();
    end
    idle_in();
    chk("pre_flush_count", count, 5);
    flush = 1'b1;
    iss_ready = 1'b1;
    set_enq(7'h51, 6'd1, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, 16'd70, 0);
    step();
    flush = 1'b0;
    iss_ready = 1'b0;
    idle_in();
    chk("flush_count", count, 0);
    chk("flush_iss_valid", iss_valid, 0);
    set_enq(7'h52, 6'd33, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, 16'd50, 0);
    step();
    idle_in();
    chk("flush_keeps_busy_count", count, 1);
    chk("flush_keeps_busy", iss_valid, 0);
    rstn = 1'b0;
    iss_ready = 1'b1;
    set_enq(7'h53, 6'd1, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, 16'd71, 0);
    step();
    rstn = 1'b1;
    iss_ready = 1'b0;
    idle_in();
    chk("rst_count", count, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    set_enq(7'h54, 6'd33, 6'd0, 1'b1, 32'h0, 6'd0, 1'b0, 16'd51, 1);
    iss_ready = 1'b1;
    step();
    idle_in();
    chk("rst_busy_cleared", iss_valid, 1);
    chk("rst_busy_rob", iss_rob, 51);
    step();
    chk("final_count", count, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
